fpcmp_ctrl: RTL and testbench

Command sequencer and result/status stage that wraps the floating-point comparator. It accepts compare commands (predicate plus two single-precision operands) over a valid/ready handshake, registers the operands, and drives the comparator's run/stall interface. It captures the boolean result and the 5-bit exception flags {V,I,O,U,X}, accumulates the flags into a sticky status register, raises a trap when an enabled flag fires, and returns the result to the consumer over a second valid/ready handshake.

---
 rtl/fpcmp_ctrl_if.sv | 40 ++++
 rtl/fpcmp_ctrl.sv | 158 +++++++++++++++
 tb/tb_fpcmp_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpcmp_ctrl_if.sv
// Bundles the command, result, comparator, sticky-status and trap signals of fpcmp_ctrl.
// slave is the controller's view and master is the view of the driving environment.
interface fpcmp_ctrl_if ();
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_pred;
  logic [31:0] cmd_x;
  logic [31:0] cmd_y;
  logic        res_valid;
  logic        res_ready;
  logic        res_z;
  logic [4:0]  res_flags;
  logic        res_err;
  logic        cmp_run;
  logic        cmp_stall;
  logic [1:0]  cmp_pred;
  logic [31:0] cmp_x;
  logic [31:0] cmp_y;
  logic        cmp_z;
  logic [4:0]  cmp_flags;
  logic        fsr_we;
  logic [4:0]  fsr_wdata;
  logic [4:0]  fsr_sticky;
  logic [4:0]  trap_en;
  logic        trap;

  modport slave (
    input  cmd_valid, cmd_pred, cmd_x, cmd_y, res_ready,
    input  cmp_stall, cmp_z, cmp_flags, fsr_we, fsr_wdata, trap_en,
    output cmd_ready, res_valid, res_z, res_flags, res_err,
    output cmp_run, cmp_pred, cmp_x, cmp_y, fsr_sticky, trap
  );

  modport master (
    output cmd_valid, cmd_pred, cmd_x, cmd_y, res_ready,
    output cmp_stall, cmp_z, cmp_flags, fsr_we, fsr_wdata, trap_en,
    input  cmd_ready, res_valid, res_z, res_flags, res_err,
    input  cmp_run, cmp_pred, cmp_x, cmp_y, fsr_sticky, trap
  );
endinterface

// File: rtl/fpcmp_ctrl.sv
// Sequencer around the FP comparator: accepts commands, runs the comparator with a
// stall timeout, captures result/flags, keeps sticky flags and raises traps.
module fpcmp_ctrl #(
  parameter int unsigned STALL_LIMIT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fpcmp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       FLAG_V   = 5'b10000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [1:0]       pred_q, pred_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic             res_z_q, res_z_d;
  logic [4:0]       res_flags_q, res_flags_d;
  logic             res_err_q, res_err_d;
  logic             trap_q, trap_d;
  logic [4:0]       sticky_q, sticky_d;
  logic             cmd_ready_s;
  logic             accept_s;
  logic             capture_s;
  logic [4:0]       cap_flags_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      pred_q      <= 2'd0;
      x_q         <= 32'd0;
      y_q         <= 32'd0;
      res_z_q     <= 1'b0;
      res_flags_q <= 5'd0;
      res_err_q   <= 1'b0;
      trap_q      <= 1'b0;
      sticky_q    <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      pred_q      <= pred_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_z_q     <= res_z_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
      trap_q      <= trap_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next-state, capture, abort and sticky-flag logic.
  always_comb begin
    cmd_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.res_ready);
    accept_s    = bus.cmd_valid && cmd_ready_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = 1'b0;
    pred_d      = pred_q;
    x_d         = x_q;
    y_d         = y_q;
    res_z_d     = res_z_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    trap_d      = trap_q;
    sticky_d    = sticky_q;
    capture_s   = 1'b0;
    cap_flags_s = 5'd0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      EXEC: begin
        if (!bus.cmp_stall) begin
          capture_s   = 1'b1;
          cap_flags_s = bus.cmp_flags;
          res_z_d     = bus.cmp_z;
          res_flags_d = bus.cmp_flags;
          res_err_d   = 1'b0;
          trap_d      = |(bus.cmp_flags & bus.trap_en);
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Timeout is reported as an invalid-operation result.
          capture_s   = 1'b1;
          cap_flags_s = FLAG_V;
          res_z_d     = 1'b0;
          res_flags_d = FLAG_V;
          res_err_d   = 1'b1;
          trap_d      = bus.trap_en[4];
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          trap_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new command may be taken from IDLE or on the DONE handshake edge.
    if (accept_s) begin
      pred_d  = bus.cmd_pred;
      x_d     = bus.cmd_x;
      y_d     = bus.cmd_y;
      cnt_d   = '0;
      run_d   = 1'b1;
      state_d = EXEC;
    end else begin
      run_d = 1'b0;
    end

    // A software write wins over the old sticky value but still merges a capture.
    if (bus.fsr_we) begin
      sticky_d = bus.fsr_wdata | cap_flags_s;
    end else if (capture_s) begin
      sticky_d = sticky_q | cap_flags_s;
    end else begin
      sticky_d = sticky_q;
    end
  end

  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_z      = res_z_q;
  assign bus.res_flags  = res_flags_q;
  assign bus.res_err    = res_err_q;
  assign bus.trap       = trap_q;
  assign bus.cmp_run    = run_q;
  assign bus.cmp_pred   = pred_q;
  assign bus.cmp_x      = x_q;
  assign bus.cmp_y      = y_q;
  assign bus.fsr_sticky = sticky_q;

endmodule

// File: tb/tb_fpcmp_ctrl.sv
// Self-checking bench for fpcmp_ctrl: directed scenarios plus randomized operations
// checked against an operation-level reference model.
module tb_fpcmp_ctrl;

  localparam int LIMIT = 15;

  typedef struct {
    logic [1:0]  pred;
    logic [31:0] x;
    logic [31:0] y;
    logic        z;
    logic [4:0]  flags;
    int          stall;
    logic [4:0]  ten;
    int          hold;
    bit          we_cap;
  } op_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [4:0] exp_sticky;

  fpcmp_ctrl_if bus ();

  fpcmp_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.pred   = 2'($urandom_range(0, 3));
    o.x      = $urandom;
    o.y      = $urandom;
    o.z      = 1'($urandom_range(0, 1));
    o.flags  = 5'($urandom_range(0, 31));
    o.stall  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 4));
    o.ten    = 5'($urandom_range(0, 31));
    o.hold   = int'($urandom_range(0, 3));
    o.we_cap = ($urandom_range(0, 3) == 0);
    return o;
  endfunction

  function automatic op_t mk_op(input logic [1:0] p, input logic [31:0] x, input logic [31:0] y,
                                input logic z, input logic [4:0] f, input int s,
                                input logic [4:0] te, input int h, input bit we);
    op_t o;
    o.pred = p; o.x = x; o.y = y; o.z = z; o.flags = f;
    o.stall = s; o.ten = te; o.hold = h; o.we_cap = we;
    return o;
  endfunction

  // Runs one operation from acceptance to the result handshake.
  // pre: command already accepted on the previous handshake edge.
  task automatic exec_op(input op_t c, input bit pre, input bit has_next, input op_t n);
    bit          abort;
    int          exp_lat;
    int          lat;
    logic        ez;
    logic [4:0]  ef;
    logic        et;
    if (!pre) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_pred  = c.pred;
      bus.cmd_x     = c.x;
      bus.cmd_y     = c.y;
      #1;
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("run_first", 32'(bus.cmp_run), 32'd1);
    chk("cmp_pred", 32'(bus.cmp_pred), 32'(c.pred));
    chk("cmp_x", bus.cmp_x, c.x);
    chk("cmp_y", bus.cmp_y, c.y);
    chk("exec_no_valid", 32'(bus.res_valid), 32'd0);
    chk("exec_not_ready", 32'(bus.cmd_ready), 32'd0);

    abort   = (c.stall >= LIMIT);
    exp_lat = abort ? LIMIT + 1 : c.stall + 2;
    ez      = abort ? 1'b0 : c.z;
    ef      = abort ? 5'b10000 : c.flags;
    et      = abort ? c.ten[4] : |(c.flags & c.ten);
    exp_sticky = (c.we_cap ? 5'b00001 : exp_sticky) | ef;

    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.cmp_stall = (k <= c.stall);
      bus.cmp_z     = c.z;
      bus.cmp_flags = c.flags;
      bus.trap_en   = c.ten;
      bus.fsr_we    = c.we_cap && (k == exp_lat - 1);
      bus.fsr_wdata = 5'b00001;
      @(posedge clk);
      @(negedge clk);
      bus.fsr_we = 1'b0;
      chk("run_single_pulse", 32'(bus.cmp_run), 32'd0);
      if (bus.res_valid) begin
        lat = k + 1;
        break;
      end
      chk("cmp_x_stable", bus.cmp_x, c.x);
      chk("cmp_y_stable", bus.cmp_y, c.y);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("res_z", 32'(bus.res_z), 32'(ez));
    chk("res_flags", 32'(bus.res_flags), 32'(ef));
    chk("res_err", 32'(bus.res_err), 32'(abort));
    chk("trap", 32'(bus.trap), 32'(et));
    chk("fsr_sticky", 32'(bus.fsr_sticky), 32'(exp_sticky));
    bus.cmp_stall = 1'b0;

    for (int h = 0; h < c.hold; h++) begin
      bus.trap_en   = ~c.ten;
      bus.cmp_flags = 5'($urandom_range(0, 31));
      bus.cmp_z     = ~c.z;
      bus.cmd_valid = has_next;
      bus.cmd_pred  = n.pred;
      bus.cmd_x     = n.x;
      bus.cmd_y     = n.y;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_z", 32'(bus.res_z), 32'(ez));
      chk("hold_flags", 32'(bus.res_flags), 32'(ef));
      chk("hold_err", 32'(bus.res_err), 32'(abort));
      chk("hold_trap", 32'(bus.trap), 32'(et));
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end

    bus.res_ready = 1'b1;
    bus.cmd_valid = has_next;
    bus.cmd_pred  = n.pred;
    bus.cmd_x     = n.x;
    bus.cmd_y     = n.y;
    #1;
    chk("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("after_hs_valid", 32'(bus.res_valid), 32'd0);
    chk("after_hs_trap", 32'(bus.trap), 32'd0);
    chk("after_hs_ready", 32'(bus.cmd_ready), 32'(!has_next));
  endtask

  initial begin
    op_t cur;
    op_t nxt;
    bit  pre;
    bit  more;
    checks     = 0;
    errors     = 0;
    exp_sticky = 5'd0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_pred  = 2'd0;
    bus.cmd_x     = 32'd0;
    bus.cmd_y     = 32'd0;
    bus.res_ready = 1'b0;
    bus.cmp_stall = 1'b0;
    bus.cmp_z     = 1'b0;
    bus.cmp_flags = 5'd0;
    bus.fsr_we    = 1'b0;
    bus.fsr_wdata = 5'd0;
    bus.trap_en   = 5'd0;

    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_cmp_run", 32'(bus.cmp_run), 32'd0);
    chk("rst_trap", 32'(bus.trap), 32'd0);
    chk("rst_sticky", 32'(bus.fsr_sticky), 32'd0);
    chk("rst_cmp_x", bus.cmp_x, 32'd0);
    chk("rst_res_flags", 32'(bus.res_flags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Equality, then signalling NaN with trap, then a clean op keeping sticky V.
    nxt = mk_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 5'b00000, 0, 5'b00000, 0, 1'b0);
    exec_op(nxt, 1'b0, 1'b0, nxt);
    nxt = mk_op(2'b11, 32'h7F80_0001, 32'h0000_0000, 1'b0, 5'b10000, 0, 5'b10000, 2, 1'b0);
    exec_op(nxt, 1'b0, 1'b0, nxt);
    nxt = mk_op(2'b10, 32'h4000_0000, 32'h3F80_0000, 1'b0, 5'b00000, 0, 5'b11111, 0, 1'b0);
    exec_op(nxt, 1'b0, 1'b0, nxt);

    // Three stall cycles, then stall timeout.
    nxt = mk_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1, 5'b00001, 3, 5'b00000, 0, 1'b0);
    exec_op(nxt, 1'b0, 1'b0, nxt);
    nxt = mk_op(2'b10, 32'hC000_0000, 32'h4000_0000, 1'b1, 5'b00000, 99, 5'b00000, 1, 1'b0);
    exec_op(nxt, 1'b0, 1'b0, nxt);

    // Backpressure with a pending command, software write on the capture edge, back-to-back.
    cur = mk_op(2'b11, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 5'b10000, 0, 5'b00000, 4, 1'b1);
    nxt = mk_op(2'b00, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 5'b00100, 1, 5'b00100, 0, 1'b0);
    exec_op(cur, 1'b0, 1'b1, nxt);
    exec_op(nxt, 1'b1, 1'b0, nxt);

    // Randomized operations, chained back-to-back at random.
    pre = 1'b0;
    cur = rand_op();
    for (int i = 0; i < 24; i++) begin
      nxt  = rand_op();
      more = (i != 23) && ($urandom_range(0, 1) == 1);
      exec_op(cur, pre, more, nxt);
      pre = more;
      cur = nxt;
    end

    // Software write while idle.
    bus.fsr_we    = 1'b1;
    bus.fsr_wdata = 5'b10101;
    @(posedge clk);
    @(negedge clk);
    bus.fsr_we = 1'b0;
    exp_sticky = 5'b10101;
    chk("fsr_write_idle", 32'(bus.fsr_sticky), 32'(exp_sticky));

    // Reset during a stalled operation.
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = 32'hDEAD_BEEF;
    bus.cmd_y     = 32'h0BAD_F00D;
    bus.cmp_stall = 1'b1;
    bus.trap_en   = 5'b11111;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_run", 32'(bus.cmp_run), 32'd0);
    chk("mid_rst_sticky", 32'(bus.fsr_sticky), 32'd0);
    chk("mid_rst_cmp_x", bus.cmp_x, 32'd0);
    chk("mid_rst_err", 32'(bus.res_err), 32'd0);
    chk("mid_rst_trap", 32'(bus.trap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cmp_stall = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(bus.res_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
